// File: rtl/multi_mode_game_counter_if.sv
// multi_mode_game_counter_if: control inputs and score/status outputs of the game counter
interface multi_mode_game_counter_if #(
  parameter int WIDTH   = 5,
  parameter int SCORE_W = 4
);
  logic               en;
  logic [1:0]         mode;
  logic               init;
  logic [WIDTH-1:0]   init_value;
  logic [WIDTH-1:0]   count;
  logic               winner;
  logic               loser;
  logic [SCORE_W-1:0] win_score;
  logic [SCORE_W-1:0] lose_score;
  logic               gameover;
  logic [1:0]         who;
  modport master (
    output en, mode, init, init_value,
    input  count, winner, loser, win_score, lose_score, gameover, who
  );
  modport slave (
    input  en, mode, init, init_value,
    output count, winner, loser, win_score, lose_score, gameover, who
  );
endinterface

// File: rtl/multi_mode_game_counter.sv
// multi_mode_game_counter: up/down step counter scoring MAX/0 landings, with auto-restarting games
module multi_mode_game_counter #(
  parameter int WIDTH      = 5,
  parameter int SCORE_W    = 4,
  parameter int TARGET     = 15,
  parameter int STEP_SMALL = 1,
  parameter int STEP_LARGE = 2
) (
  input logic                      clk,
  input logic                      rst,
  multi_mode_game_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  localparam logic [WIDTH-1:0]   MAX = '1;
  localparam logic [SCORE_W-1:0] TGT = SCORE_W'(TARGET);
  state_t             state_q;
  logic [WIDTH-1:0]   count_q, step_d, nxt_d, start_d;
  logic [SCORE_W-1:0] win_q, lose_q, win_d, lose_d;
  logic               winner_q, loser_q, over_q;
  logic [1:0]         who_q;
  // step size, stepped value, start value and incremented scores
  always_comb begin
    step_d  = bus.mode[0] ? WIDTH'(STEP_LARGE) : WIDTH'(STEP_SMALL);
    nxt_d   = bus.mode[1] ? count_q - step_d : count_q + step_d;
    start_d = bus.mode[1] ? MAX : '0;
    win_d   = win_q + 1'b1;
    lose_d  = lose_q + 1'b1;
  end
  // game FSM; pulses default low and are raised only by a scoring step
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      win_q    <= '0;
      lose_q   <= '0;
      winner_q <= 1'b0;
      loser_q  <= 1'b0;
      over_q   <= 1'b0;
      who_q    <= 2'b00;
    end else begin
      winner_q <= 1'b0;
      loser_q  <= 1'b0;
      over_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= start_d;
          state_q <= RUN;
        end
        RUN: begin
          if (bus.init) count_q <= bus.init_value;
          else if (bus.en) begin
            count_q <= nxt_d;
            if (nxt_d == MAX) begin
              winner_q <= 1'b1;
              win_q    <= win_d;
              if (win_d == TGT) begin
                over_q  <= 1'b1;
                who_q   <= 2'b10;
                state_q <= OVER;
              end
            end else if (nxt_d == '0) begin
              loser_q <= 1'b1;
              lose_q  <= lose_d;
              if (lose_d == TGT) begin
                over_q  <= 1'b1;
                who_q   <= 2'b01;
                state_q <= OVER;
              end
            end
          end
        end
        OVER: begin
          count_q <= start_d;
          win_q   <= '0;
          lose_q  <= '0;
          state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.count      = count_q;
  assign bus.winner     = winner_q;
  assign bus.loser      = loser_q;
  assign bus.win_score  = win_q;
  assign bus.lose_score = lose_q;
  assign bus.gameover   = over_q;
  assign bus.who        = who_q;
endmodule

// File: tb/tb_multi_mode_game_counter.sv
// tb_multi_mode_game_counter: directed checks of counting, scoring, loads, game end and reset
module tb_multi_mode_game_counter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  multi_mode_game_counter_if #(.WIDTH(5), .SCORE_W(4)) b ();
  multi_mode_game_counter_if #(.WIDTH(5), .SCORE_W(4)) b3 ();
  assign b3.en         = b.en;
  assign b3.mode       = b.mode;
  assign b3.init       = b.init;
  assign b3.init_value = b.init_value;
  multi_mode_game_counter dut (.clk(clk), .rst(rst), .bus(b));
  multi_mode_game_counter #(.TARGET(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    b.en = 1'b1;
    b.mode = 2'b00;
    b.init = 1'b0;
    b.init_value = '0;
    tick();
    tick();
    chk("rst count", b.count, 0);
    chk("rst winner", b.winner, 0);
    chk("rst loser", b.loser, 0);
    chk("rst win_score", b.win_score, 0);
    chk("rst lose_score", b.lose_score, 0);
    chk("rst gameover", b.gameover, 0);
    chk("rst who", b.who, 0);
    rst = 1'b0;
    tick();
    chk("t1 start", b.count, 0);
    chk("t4 start", b3.count, 0);
    for (int k = 1; k <= 97; k++) begin
      tick();
      if (k <= 32) begin
        chk("t1 count", b.count, k % 32);
        chk("t1 winner", b.winner, k == 31);
        chk("t1 loser", b.loser, k == 32);
      end
      if (k == 31) chk("t1 win_score", b.win_score, 1);
      if (k == 32) chk("t1 lose_score", b.lose_score, 1);
      chk("t4 gameover", b3.gameover, k == 95);
      if (k == 95) begin
        chk("t4 end win_score", b3.win_score, 3);
        chk("t4 end lose_score", b3.lose_score, 2);
        chk("t4 end who", b3.who, 2);
        chk("t4 end count", b3.count, 31);
        chk("t4 end winner", b3.winner, 1);
      end
      if (k == 96) begin
        chk("t4 over count", b3.count, 0);
        chk("t4 over win_score", b3.win_score, 0);
        chk("t4 over lose_score", b3.lose_score, 0);
        chk("t4 over who", b3.who, 2);
        chk("t4 over winner", b3.winner, 0);
      end
      if (k == 97) begin
        chk("t4 restart count", b3.count, 1);
        chk("t4 restart who", b3.who, 2);
      end
    end
    rst = 1'b1;
    b.mode = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t2 start", b.count, 31);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t2 count", b.count, (31 - 2 * k) & 31);
      chk("t2 loser", b.loser, 0);
      chk("t2 winner", b.winner, k == 16);
    end
    chk("t2 win_score", b.win_score, 1);
    rst = 1'b1;
    b.mode = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    repeat (7) tick();
    chk("t3 count7", b.count, 7);
    b.init = 1'b1;
    b.init_value = 5'd30;
    tick();
    chk("t3 init count", b.count, 30);
    chk("t3 init winner", b.winner, 0);
    chk("t3 init loser", b.loser, 0);
    chk("t3 init win_score", b.win_score, 0);
    b.init = 1'b0;
    tick();
    chk("t3 step count", b.count, 31);
    chk("t3 step winner", b.winner, 1);
    chk("t3 step win_score", b.win_score, 1);
    b.init = 1'b1;
    b.init_value = 5'd12;
    tick();
    b.init = 1'b0;
    b.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5 hold count", b.count, 12);
      chk("t5 hold winner", b.winner, 0);
      chk("t5 hold loser", b.loser, 0);
    end
    rst = 1'b1;
    tick();
    chk("t5 rst count", b.count, 0);
    chk("t5 rst win_score", b.win_score, 0);
    chk("t5 rst who", b.who, 0);
    rst = 1'b0;
    b.mode = 2'b10;
    tick();
    chk("t5 idle start", b.count, 31);
    b.mode = 2'b00;
    b.init = 1'b1;
    b.init_value = 5'd5;
    tick();
    chk("t6 init5", b.count, 5);
    b.init = 1'b0;
    b.mode = 2'b10;
    b.en = 1'b1;
    tick();
    chk("t6 no reload", b.count, 4);
    for (int v = 3; v >= 0; v--) begin
      tick();
      chk("t6 count", b.count, v);
      chk("t6 loser", b.loser, v == 0);
    end
    chk("t6 lose_score", b.lose_score, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
